// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX FSM encoding for mmio_uart_tx.
// Pure declarations with no logic, so there is no latency or backpressure.
package mmio_uart_tx_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int CTRL_TXEN = 0;
    localparam int CTRL_IRQ  = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    // The STATUS count field is 4 bits wide, so deeper FIFOs report 15.
    function automatic logic [3:0] sat_cnt(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by a memory-mapped peripheral.
// Reads are combinational; there is no stall path, so writes always complete.
interface mmio_uart_tx_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic        sel;
    logic [31:0] rd_data;

    modport master (output mem_ren, mem_wen, mem_addr, mem_dout, input sel, rd_data);
    modport slave  (input mem_ren, mem_wen, mem_addr, mem_dout, output sel, rd_data);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Generic FIFO with a count register that separates full from empty.
// Head is visible combinationally; a push while full is accepted only alongside a pop.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == DEPTH[AW:0]);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter, 8N1 LSB first; UART_PARITY_EN adds an even-parity bit.
// Reads are 0-cycle; the FSM leaves IDLE one edge after a TXDATA push.
// No stall to the core: a push to a full FIFO is dropped and flags overflow.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          CLK_DIV    = 100,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          uart_txd,
    output logic          irq
);
    localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
`ifdef UART_PARITY_EN
    localparam logic PAR_FLAG = 1'b1;
`else
    localparam logic PAR_FLAG = 1'b0;
`endif

    tx_state_e      state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           par_q, par_d;
    logic           ovf_q, ovf_d;
    logic           tx_en_q, tx_en_d;
    logic           irq_en_q, irq_en_d;
    logic           irq_q;

    logic           wr_en, push, pop, can_start, baud_done, busy;
    logic [1:0]     off;
    logic [7:0]     fifo_dout;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_cnt;
    logic [31:0]    status;
    logic           unused_bits;

    assign bus.sel     = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign off         = bus.mem_addr[3:2];
    assign wr_en       = bus.sel & bus.mem_wen;
    assign push        = wr_en & (off == OFF_TXDATA);
    assign unused_bits = ^{bus.mem_dout[31:8], bus.mem_addr[1:0]};

    uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.mem_dout[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign can_start = tx_en_q & ~fifo_empty;
    assign baud_done = (cnt_q == 16'd0);
    assign busy      = (state_q != S_IDLE) | ~fifo_empty;
    assign status    = {23'd0, PAR_FLAG, sat_cnt(32'(fifo_cnt)), ovf_q, busy, fifo_empty, fifo_full};

    always_comb begin
        ovf_d    = ovf_q;
        tx_en_d  = tx_en_q;
        irq_en_d = irq_en_q;
        if (wr_en && off == OFF_STATUS && bus.mem_dout[ST_OVF]) ovf_d = 1'b0;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        if (wr_en && off == OFF_CTRL) begin
            tx_en_d  = bus.mem_dout[CTRL_TXEN];
            irq_en_d = bus.mem_dout[CTRL_IRQ];
        end
    end

    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.sel && bus.mem_ren) begin
            case (off)
                OFF_STATUS: bus.rd_data = status;
                OFF_CTRL:   bus.rd_data = {30'd0, irq_en_q, tx_en_q};
                default:    bus.rd_data = 32'd0;
            endcase
        end
    end

    // STOP chains straight into the next START so back-to-back frames have no gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pop     = 1'b0;
        if (state_q != S_IDLE) cnt_d = baud_done ? DIV_M1 : cnt_q - 16'd1;
        case (state_q)
            S_IDLE: if (can_start) begin
                pop     = 1'b1;
                shreg_d = fifo_dout;
                par_d   = ^fifo_dout;
                cnt_d   = DIV_M1;
                state_d = S_START;
            end
            S_START: if (baud_done) begin
                bit_d   = 3'd0;
                state_d = S_DATA;
            end
            S_DATA: if (baud_done) begin
                shreg_d = shreg_q >> 1;
                bit_d   = bit_q + 3'd1;
`ifdef UART_PARITY_EN
                if (bit_q == 3'd7) state_d = S_PARITY;
`else
                if (bit_q == 3'd7) state_d = S_STOP;
`endif
            end
            S_PARITY: if (baud_done) state_d = S_STOP;
            S_STOP: if (baud_done) begin
                if (can_start) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    par_d   = ^fifo_dout;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        uart_txd = 1'b1;
        case (state_q)
            S_START:  uart_txd = 1'b0;
            S_DATA:   uart_txd = shreg_q[0];
            S_PARITY: uart_txd = par_q;
            default:  uart_txd = 1'b1;
        endcase
    end

    assign irq = irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'd0;
            par_q    <= 1'b0;
            ovf_q    <= 1'b0;
            tx_en_q  <= 1'b1;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            ovf_q    <= ovf_d;
            tx_en_q  <= tx_en_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & fifo_empty & (state_q == S_IDLE);
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLK_DIV=4, FIFO_DEPTH=8.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef UART_PARITY_EN
    localparam int          NB = 11;
    localparam logic [31:0] PB = 32'h100;
`else
    localparam int          NB = 10;
    localparam logic [31:0] PB = 32'h000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic txd, irq;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(4), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .uart_txd (txd),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        bus.mem_wen  = 1'b1;
        bus.mem_addr = BASE + {28'd0, off};
        bus.mem_dout = d;
        @(posedge clk);
        #1;
        bus.mem_wen  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        bus.mem_ren  = 1'b1;
        bus.mem_addr = BASE + {28'd0, off};
        #1;
        d = bus.rd_data;
        bus.mem_ren  = 1'b0;
    endtask

    // Expected line levels, index 0 = start bit; unused top bit stays 1.
    function automatic logic [10:0] frm(input logic [7:0] b);
`ifdef UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    // Samples each bit mid-cell; starts and ends on a frame boundary.
    task automatic rx_frame(output logic [10:0] v);
        v = '1;
        for (int b = 0; b < NB; b++) begin
            repeat (2) cyc();
            v[b] = txd;
            repeat (2) cyc();
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [10:0] fr;
        logic [10:0] v;
        bus.mem_ren  = 1'b0;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = 32'd0;
        bus.mem_dout = 32'd0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (50) cyc();
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd(4'h4, d); check("rst_status", d, 32'h02 | PB);
        rd(4'h8, d); check("rst_ctrl", d, 32'h01);
        rd(4'h0, d); check("rd_txdata", d, 32'h0);
        rd(4'hC, d); check("rd_off3", d, 32'h0);
        bus.mem_ren  = 1'b1;
        bus.mem_addr = 32'h0000_1004;
        #1;
        check("unsel_sel", {31'd0, bus.sel}, 32'd0);
        check("unsel_rd", bus.rd_data, 32'd0);
        bus.mem_addr = BASE + 32'h4;
        #1;
        check("win_sel", {31'd0, bus.sel}, 32'd1);
        bus.mem_ren  = 1'b0;

        // Single byte 0xA5, cycle-accurate line check
        wr(4'h0, 32'hA5);
        check("a5_edge_txd", {31'd0, txd}, 32'd1);
        fr = frm(8'hA5);
        for (int k = 0; k < NB * 4; k++) begin
            cyc();
            check("a5_bit", {31'd0, txd}, {31'd0, fr[k/4]});
            if (k == NB * 4 - 1) begin
                rd(4'h4, d);
                check("a5_busy_last", {31'd0, d[2]}, 32'd1);
            end
        end
        cyc();
        rd(4'h4, d); check("a5_done_status", d, 32'h02 | PB);
        check("a5_done_txd", {31'd0, txd}, 32'd1);

        // Overflow with tx disabled
        wr(4'h8, 32'h0);
        for (int i = 0; i < 9; i++) wr(4'h0, 32'h10 + i);
        rd(4'h4, d); check("ovf_status", d, 32'h8D | PB);
        wr(4'h4, 32'h08);
        rd(4'h4, d); check("ovf_cleared", d, 32'h85 | PB);

        // Enable tx with a push coinciding with the first pop while full
        wr(4'h8, 32'h1);
        wr(4'h0, 32'h19);
        rd(4'h4, d); check("full_pushpop", d, 32'h85 | PB);
        for (int j = 0; j < 9; j++) begin
            rx_frame(v);
            check("fifo_frame", {21'd0, v}, {21'd0, frm((j < 8) ? 8'(8'h10 + j) : 8'h19)});
        end
        rd(4'h4, d); check("drain_status", d, 32'h02 | PB);

        // irq timing around one frame
        wr(4'h8, 32'h3);
        check("irq_lag", {31'd0, irq}, 32'd0);
        cyc();
        check("irq_idle", {31'd0, irq}, 32'd1);
        wr(4'h0, 32'h3C);
        cyc();
        check("irq_frame", {31'd0, irq}, 32'd0);
        repeat (NB * 4) cyc();
        check("irq_stop_end", {31'd0, irq}, 32'd0);
        cyc();
        check("irq_rise", {31'd0, irq}, 32'd1);

        // Reset mid-DATA with a byte still queued
        wr(4'h8, 32'h1);
        wr(4'h0, 32'h00);
        wr(4'h0, 32'h55);
        repeat (6) cyc();
        check("mid_data_txd", {31'd0, txd}, 32'd0);
        rd(4'h4, d); check("mid_status", d, 32'h14 | PB);
        rst = 1'b0;
        #1;
        check("rst_mid_txd", {31'd0, txd}, 32'd1);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        rd(4'h4, d); check("rst_mid_status", d, 32'h02 | PB);
        rst = 1'b1;
        cyc();
        check("post_rst_txd", {31'd0, txd}, 32'd1);
        rd(4'h8, d); check("post_rst_ctrl", d, 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
